// File: rtl/kronos_types.sv
// Shared types for the Kronos fetch front end.
package kronos_types;

    localparam int PF_MAX_DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } pf_entry_t;

endpackage

// File: rtl/kronos_pf_fifo.sv
// Synchronous circular-buffer FIFO. Clear empties it; pop of an empty queue is ignored.
module kronos_pf_fifo
    import kronos_types::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = pf_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  T                       din,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || DEPTH > PF_MAX_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("kronos_pf_fifo: DEPTH must be a power of 2 in 2..%0d", PF_MAX_DEPTH);
    end

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/kronos_prefetch.sv
// Kronos instruction prefetcher: sequential word fetch into a queue, redirect on branch.
module kronos_prefetch
    import kronos_types::*;
#(
    parameter logic [31:0] BOOT_ADDR    = 32'h0,
    parameter int          DEPTH        = 4,
    parameter bit          FALL_THROUGH = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [31:0]            instr_addr,
    input  logic [31:0]            instr_data,
    output logic                   instr_req,
    input  logic                   instr_ack,
    input  logic                   branch,
    input  logic [31:0]            branch_target,
    output logic [31:0]            fetch_pc,
    output logic [31:0]            fetch_ir,
    output logic                   fetch_vld,
    input  logic                   fetch_rdy,
    output logic [$clog2(DEPTH):0] pf_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] REQ_DROP = 2'd2;

    logic [1:0]    state;
    logic [31:0]   pc;
    logic [31:0]   req_addr;
    logic [31:0]   target;
    pf_entry_t     ack_entry;
    pf_entry_t     head;
    pf_entry_t     shown;
    logic          empty;
    logic          full;
    logic          ack_any;
    logic          ack_live;
    logic          ft_hit;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          can_issue;

    assign target     = branch_target & 32'hFFFF_FFFC;
    assign instr_req  = (state != IDLE);
    assign instr_addr = req_addr;
    assign pf_count   = count;

    // An ack is only meaningful while a request is outstanding; in REQ_DROP it is discarded.
    assign ack_any   = instr_ack && instr_req;
    assign ack_live  = instr_ack && (state == REQ);
    assign ack_entry = '{pc: req_addr, ir: instr_data};

    assign ft_hit    = FALL_THROUGH && empty && ack_live;
    assign fetch_vld = !branch && (!empty || ft_hit);
    assign pop       = fetch_vld && fetch_rdy && !empty;
    assign push      = ack_live && !branch && !(ft_hit && fetch_rdy) && (!full || pop);

    assign shown    = ft_hit ? ack_entry : head;
    assign fetch_pc = fetch_vld ? shown.pc : '0;
    assign fetch_ir = fetch_vld ? shown.ir : '0;

    // A slot freed by a pop this cycle counts toward the next issue.
    assign count_next = count + CW'(push) - CW'(pop);
    assign can_issue  = (count_next < CW'(DEPTH));

    kronos_pf_fifo #(
        .DEPTH (DEPTH),
        .T     (pf_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (branch),
        .din   (ack_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // pc always holds the address of the next request to issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= BOOT_ADDR;
        end else if (branch) begin
            if (instr_req && !instr_ack) begin
                state <= REQ_DROP;
                pc    <= target;
            end else begin
                state    <= REQ;
                req_addr <= target;
                pc       <= target + 32'd4;
            end
        end else if (state == IDLE || ack_any) begin
            if (can_issue) begin
                state    <= REQ;
                req_addr <= pc;
                pc       <= pc + 32'd4;
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_kronos_prefetch.sv
// Directed bench for kronos_prefetch: three configurations with simple memory models.
module tb_kronos_prefetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_run;
    int   n_fail;

    // Instance A: DEPTH=4, FALL_THROUGH=0, BOOT_ADDR=0, latency-programmable memory
    logic [31:0] a_addr, a_data, a_bt, a_pc, a_ir;
    logic        a_req, a_ack, a_br, a_vld, a_rdy;
    logic [2:0]  a_cnt;
    int          a_lat;
    int          a_wait = 0;

    assign a_ack  = a_req && (a_wait >= a_lat);
    assign a_data = a_ack ? ~a_addr : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (!a_req || a_ack) a_wait <= 0;
        else a_wait <= a_wait + 1;
    end

    kronos_prefetch #(.BOOT_ADDR(32'h0), .DEPTH(4), .FALL_THROUGH(1'b0)) u_a (
        .clk(clk), .rst(rst), .instr_addr(a_addr), .instr_data(a_data), .instr_req(a_req),
        .instr_ack(a_ack), .branch(a_br), .branch_target(a_bt), .fetch_pc(a_pc),
        .fetch_ir(a_ir), .fetch_vld(a_vld), .fetch_rdy(a_rdy), .pf_count(a_cnt)
    );

    // Instance B: FALL_THROUGH=1, BOOT_ADDR=0x40, always-ack memory
    logic [31:0] b_addr, b_data, b_bt, b_pc, b_ir;
    logic        b_req, b_ack, b_br, b_vld, b_rdy;
    logic [2:0]  b_cnt;

    assign b_ack  = b_req;
    assign b_data = b_ack ? ~b_addr : 32'hDEAD_BEEF;

    kronos_prefetch #(.BOOT_ADDR(32'h40), .DEPTH(4), .FALL_THROUGH(1'b1)) u_b (
        .clk(clk), .rst(rst), .instr_addr(b_addr), .instr_data(b_data), .instr_req(b_req),
        .instr_ack(b_ack), .branch(b_br), .branch_target(b_bt), .fetch_pc(b_pc),
        .fetch_ir(b_ir), .fetch_vld(b_vld), .fetch_rdy(b_rdy), .pf_count(b_cnt)
    );

    // Instance C: BOOT_ADDR near the top of the address space, gateable ack plus spurious ack
    logic [31:0] c_addr, c_data, c_bt, c_pc, c_ir;
    logic        c_req, c_ack, c_br, c_vld, c_rdy, c_en, c_spur;
    logic [2:0]  c_cnt;

    assign c_ack  = (c_req && c_en) || c_spur;
    assign c_data = c_ack ? ~c_addr : 32'hDEAD_BEEF;

    kronos_prefetch #(.BOOT_ADDR(32'hFFFF_FFF8), .DEPTH(4), .FALL_THROUGH(1'b0)) u_c (
        .clk(clk), .rst(rst), .instr_addr(c_addr), .instr_data(c_data), .instr_req(c_req),
        .instr_ack(c_ack), .branch(c_br), .branch_target(c_bt), .fetch_pc(c_pc),
        .fetch_ir(c_ir), .fetch_vld(c_vld), .fetch_rdy(c_rdy), .pf_count(c_cnt)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Leaves time just after the first edge with rst low (cycle R, no request yet).
    task automatic do_reset;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        n_run++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", a_req); end
        n_run++; if (a_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", a_vld); end
        n_run++; if (a_pc !== 32'h0 || a_ir !== 32'h0) begin n_fail++; $display("FAIL reset_pc_ir: got %h/%h want 0/0", a_pc, a_ir); end
        n_run++; if (a_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", a_cnt); end
        step();
        rst = 1'b0;
        #1;
        n_run++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL reset_release_req: got %b want 0", a_req); end
    endtask

    task automatic test_stream;
        a_lat = 0;
        a_rdy = 1'b1;
        do_reset();
        step();
        n_run++; if (a_req !== 1'b1 || a_addr !== 32'h0) begin n_fail++; $display("FAIL stream_first_req: got req=%b addr=%h want 1/00000000", a_req, a_addr); end
        n_run++; if (a_vld !== 1'b0) begin n_fail++; $display("FAIL stream_no_vld_ack_cycle: got %b want 0", a_vld); end
        step();
        n_run++; if (a_addr !== 32'h4) begin n_fail++; $display("FAIL stream_addr1: got %h want 4", a_addr); end
        n_run++; if (a_vld !== 1'b1 || a_pc !== 32'h0 || a_ir !== ~32'h0) begin n_fail++; $display("FAIL stream_out0: got vld=%b pc=%h ir=%h want 1/0/ffffffff", a_vld, a_pc, a_ir); end
        n_run++; if (a_cnt !== 3'd1) begin n_fail++; $display("FAIL stream_count: got %0d want 1", a_cnt); end
        step();
        n_run++; if (a_addr !== 32'h8 || a_pc !== 32'h4) begin n_fail++; $display("FAIL stream_out1: got addr=%h pc=%h want 8/4", a_addr, a_pc); end
        step();
        n_run++; if (a_vld !== 1'b1 || a_pc !== 32'h8 || a_cnt !== 3'd1) begin n_fail++; $display("FAIL stream_out2: got vld=%b pc=%h cnt=%0d want 1/8/1", a_vld, a_pc, a_cnt); end
    endtask

    task automatic test_full;
        int acks;
        a_lat = 0;
        a_rdy = 1'b0;
        do_reset();
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (a_ack) acks++;
        end
        n_run++; if (acks != 4) begin n_fail++; $display("FAIL full_ack_count: got %0d want 4", acks); end
        n_run++; if (a_cnt !== 3'd4 || a_req !== 1'b0) begin n_fail++; $display("FAIL full_state: got cnt=%0d req=%b want 4/0", a_cnt, a_req); end
        n_run++; if (a_vld !== 1'b1 || a_pc !== 32'h0 || a_ir !== ~32'h0) begin n_fail++; $display("FAIL full_head_stable: got vld=%b pc=%h ir=%h want 1/0/ffffffff", a_vld, a_pc, a_ir); end
        a_rdy = 1'b1;
        step();
        a_rdy = 1'b0;
        #1;
        acks = a_ack ? 1 : 0;
        n_run++; if (a_req !== 1'b1 || a_addr !== 32'h10 || a_cnt !== 3'd3) begin n_fail++; $display("FAIL full_refill_req: got req=%b addr=%h cnt=%0d want 1/10/3", a_req, a_addr, a_cnt); end
        step();
        n_run++; if (a_cnt !== 3'd4 || a_pc !== 32'h4 || a_req !== 1'b0) begin n_fail++; $display("FAIL full_refilled: got cnt=%0d pc=%h req=%b want 4/4/0", a_cnt, a_pc, a_req); end
        for (int i = 0; i < 5; i++) begin
            if (a_ack) acks++;
            step();
        end
        n_run++; if (acks != 1) begin n_fail++; $display("FAIL full_one_refill: got %0d acks want 1", acks); end
    endtask

    task automatic test_branch_drop;
        bit          found;
        bit          got_addr;
        bit          got_fire;
        bit          seen8;
        logic [31:0] new_addr;
        logic [31:0] fire_pc;
        logic [31:0] fire_ir;
        a_lat = 3;
        a_rdy = 1'b1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (a_req && a_addr == 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        n_run++; if (!found) begin n_fail++; $display("FAIL drop_find_req8: got none want req for 00000008"); end
        a_bt = 32'h100;
        a_br = 1'b1;
        #1;
        n_run++; if (a_vld !== 1'b0) begin n_fail++; $display("FAIL drop_vld_forced: got %b want 0", a_vld); end
        step();
        a_br = 1'b0;
        got_addr = 1'b0; got_fire = 1'b0; seen8 = 1'b0;
        new_addr = '0; fire_pc = '0; fire_ir = '0;
        for (int i = 0; i < 30; i++) begin
            if (a_req && a_addr != 32'h8 && !got_addr) begin got_addr = 1'b1; new_addr = a_addr; end
            if (a_vld && a_rdy && !got_fire) begin got_fire = 1'b1; fire_pc = a_pc; fire_ir = a_ir; end
            if (a_vld && a_pc == 32'h8) seen8 = 1'b1;
            step();
        end
        n_run++; if (!got_addr || new_addr !== 32'h100) begin n_fail++; $display("FAIL drop_next_addr: got %h (seen=%b) want 100", new_addr, got_addr); end
        n_run++; if (!got_fire || fire_pc !== 32'h100 || fire_ir !== ~32'h100) begin n_fail++; $display("FAIL drop_first_fetch: got pc=%h ir=%h want 100/fffffeff", fire_pc, fire_ir); end
        n_run++; if (seen8) begin n_fail++; $display("FAIL drop_discard: got pc 00000008 presented want never"); end
    endtask

    task automatic test_branch_ack;
        bit          found;
        bit          bad;
        bit          got_fire;
        logic [31:0] fire_pc;
        a_lat = 0;
        a_rdy = 1'b1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (a_req && a_ack && a_addr == 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        n_run++; if (!found) begin n_fail++; $display("FAIL bra_find_ack8: got none want ack for 00000008"); end
        a_bt = 32'h203;
        a_br = 1'b1;
        #1;
        n_run++; if (a_vld !== 1'b0) begin n_fail++; $display("FAIL bra_vld_forced: got %b want 0", a_vld); end
        step();
        a_br = 1'b0;
        #1;
        n_run++; if (a_req !== 1'b1 || a_addr !== 32'h200) begin n_fail++; $display("FAIL bra_target_req: got req=%b addr=%h want 1/200", a_req, a_addr); end
        bad = 1'b0; got_fire = 1'b0; fire_pc = '0;
        for (int i = 0; i < 10; i++) begin
            if (a_vld && a_ir == ~32'h8) bad = 1'b1;
            if (a_vld && a_rdy && !got_fire) begin got_fire = 1'b1; fire_pc = a_pc; end
            step();
        end
        n_run++; if (bad) begin n_fail++; $display("FAIL bra_discard: got ir fffffff7 presented want never"); end
        n_run++; if (!got_fire || fire_pc !== 32'h200) begin n_fail++; $display("FAIL bra_first_fetch: got %h want 200", fire_pc); end
    endtask

    task automatic test_fall_through;
        b_rdy = 1'b1;
        do_reset();
        step();
        n_run++; if (b_req !== 1'b1 || b_addr !== 32'h40) begin n_fail++; $display("FAIL ft_req: got req=%b addr=%h want 1/40", b_req, b_addr); end
        n_run++; if (b_vld !== 1'b1 || b_pc !== 32'h40 || b_ir !== ~32'h40) begin n_fail++; $display("FAIL ft_same_cycle: got vld=%b pc=%h ir=%h want 1/40/ffffffbf", b_vld, b_pc, b_ir); end
        n_run++; if (b_cnt !== 3'd0) begin n_fail++; $display("FAIL ft_count_ack: got %0d want 0", b_cnt); end
        step();
        n_run++; if (b_cnt !== 3'd0 || b_pc !== 32'h44) begin n_fail++; $display("FAIL ft_bypass_next: got cnt=%0d pc=%h want 0/44", b_cnt, b_pc); end
        b_rdy = 1'b0;
        do_reset();
        step();
        n_run++; if (b_vld !== 1'b1 || b_pc !== 32'h40) begin n_fail++; $display("FAIL ft_stall_present: got vld=%b pc=%h want 1/40", b_vld, b_pc); end
        step();
        n_run++; if (b_vld !== 1'b1 || b_pc !== 32'h40 || b_cnt !== 3'd1) begin n_fail++; $display("FAIL ft_stall_pushed: got vld=%b pc=%h cnt=%0d want 1/40/1", b_vld, b_pc, b_cnt); end
        b_rdy = 1'b1;
    endtask

    task automatic test_wrap_and_reset;
        c_en = 1'b1;
        c_rdy = 1'b1;
        do_reset();
        step();
        n_run++; if (c_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_addr0: got %h want fffffff8", c_addr); end
        step();
        n_run++; if (c_addr !== 32'hFFFF_FFFC || c_pc !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_addr1: got addr=%h pc=%h want fffffffc/fffffff8", c_addr, c_pc); end
        step();
        n_run++; if (c_addr !== 32'h0 || c_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr2: got addr=%h pc=%h want 0/fffffffc", c_addr, c_pc); end
        c_en = 1'b0;
        do_reset();
        step();
        step();
        n_run++; if (c_req !== 1'b1 || c_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL rstmid_pending: got req=%b addr=%h want 1/fffffff8", c_req, c_addr); end
        rst = 1'b1;
        step();
        n_run++; if (c_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_drop: got %b want 0", c_req); end
        rst = 1'b0;
        c_spur = 1'b1;
        step();
        c_spur = 1'b0;
        #1;
        n_run++; if (c_cnt !== 3'd0 || c_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_spurious_ack: got cnt=%0d vld=%b want 0/0", c_cnt, c_vld); end
        n_run++; if (c_req !== 1'b1 || c_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL rstmid_restart: got req=%b addr=%h want 1/fffffff8", c_req, c_addr); end
        c_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_run = 0;
        n_fail = 0;
        rst = 1'b1;
        a_br = 1'b0; a_bt = '0; a_rdy = 1'b1; a_lat = 0;
        b_br = 1'b0; b_bt = '0; b_rdy = 1'b1;
        c_br = 1'b0; c_bt = '0; c_rdy = 1'b1; c_en = 1'b1; c_spur = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_full();
        test_branch_drop();
        test_branch_ack();
        test_fall_through();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/kronos_prefetch.md
Name: kronos_prefetch

Overview:
- Parametrised instruction-fetch front end for the Kronos core. It is the successor to the single-entry fetch stage.
- Issues sequential word fetches on the req/ack instruction bus into a DEPTH-entry prefetch queue, and presents {pc, ir} to decode via a valid/ready handshake.
- Redirects and flushes on branch from EX.
- Optional fall-through mode removes the queue latency when the queue is empty.

Parameters:
- BOOT_ADDR, 32'h0, PC fetched first after reset.
- DEPTH, 4, prefetch queue entries; power of 2, 2..16.
- FALL_THROUGH, 0, 1 = instruction acked into an empty queue is presented to decode in the same cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- instr_addr  out  32  fetch address, word aligned.
- instr_data  in  32  fetch data, valid when instr_ack=1.
- instr_req  out  1  fetch request.
- instr_ack  in  1  fetch response; single cycle, same cycle as data.
- branch  in  1  redirect strobe from EX.
- branch_target  in  32  redirect PC; bits [1:0] are ignored and forced to 0.
- fetch_pc  out  32  PC of the presented instruction.
- fetch_ir  out  32  presented instruction.
- fetch_vld  out  1  presented instruction is valid.
- fetch_rdy  in  1  decode accepts it.
- pf_count  out  $clog2(DEPTH)+1  queue occupancy, for debug/perf.

Behaviour:
- Reset (rst=1 at a clk edge):
  - fetch PC = BOOT_ADDR.
  - Queue empty, pf_count=0.
  - instr_req=0, fetch_vld=0, fetch_pc=0, fetch_ir=0.
  - Inflight/drop flags cleared.
  - Reset mid-request abandons the request. A later instr_ack with no request outstanding is ignored.
  - First instr_req=1 occurs in the cycle after rst deasserts.
- Bus rules:
  - Once instr_req=1, instr_addr and instr_req stay stable until instr_ack. At most one request is outstanding.
  - A new request can be issued in the same cycle as the ack of the previous one, giving one word per cycle back-to-back.
- Issue condition: pf_count + inflight < DEPTH, counting an entry being popped in the same cycle as free.
- On ack: push {addr, data}; fetch PC += 4. The PC wraps 32'hFFFF_FFFC -> 0 with no exception.
- Queue is a circular buffer with wrap-around pointers. Simultaneous push and pop leaves the count unchanged.
- Output timing:
  - FALL_THROUGH=0: fetch_vld = queue non-empty. An ack at cycle N is visible at cycle N+1.
  - FALL_THROUGH=1: when the queue is empty, an acked word drives fetch_* and fetch_vld in cycle N. If fetch_rdy=1 it is consumed without being written; otherwise it is pushed.
- fetch_pc and fetch_ir are stable while fetch_vld=1 and fetch_rdy=0.
- Branch (branch=1 in cycle N):
  - fetch_vld is forced to 0 in cycle N; no handshake completes.
  - Queue is cleared at the edge; the next fetch PC is branch_target.
  - If a request is outstanding and unacked, drop is set. The request is held until its ack, that data is discarded, and then branch_target is requested.
  - If instr_ack arrives in cycle N, that data is discarded and branch_target is requested in N+1.
  - If no request is outstanding, branch_target is requested in N+1.
  - Back-to-back branches: the last target wins, and only one pending drop is tracked.
- rst has priority over branch; branch has priority over push/pop.
- Full queue: no issue; instr_req=0 until a pop occurs.

Decomposition:
- Package kronos_types gains typedef pf_entry_t (struct: pc[31:0], ir[31:0]) and localparam PF_MAX_DEPTH=16.
- Sub-module kronos_pf_fifo: generic synchronous FIFO parametrised by DEPTH and entry type. Ports: push, pop, clear, full, empty, count.
- kronos_prefetch owns the PC, the issue/inflight/drop state machine (IDLE, REQ, REQ_DROP) and the fall-through mux.

Test Plan:
- Reset release, always-ack memory, fetch_rdy=1, DEPTH=4, FALL_THROUGH=0: requests to 0x0, 0x4, 0x8 back-to-back; fetch_vld first at the cycle after the first ack; one instruction per cycle after that.
- fetch_rdy=0 with DEPTH=4: exactly 4 acks, pf_count=4, instr_req=0. Raising fetch_rdy for 1 cycle pops pc 0x0, pf_count stays 4 by the next cycle, and one new request is issued.
- Memory with 3-cycle ack latency; branch to 0x100 in the first cycle of the request for 0x8: the 0x8 data is discarded, the next instr_addr is 0x100, and the first accepted fetch_pc is 0x100.
- branch to 0x203 together with instr_ack: instr_addr=0x200 next cycle; the acked data never appears on fetch_ir.
- FALL_THROUGH=1, queue empty, ack of 0x40 with fetch_rdy=1: fetch_vld=1 and fetch_pc=0x40 in the ack cycle; pf_count stays 0.
- BOOT_ADDR=32'hFFFF_FFF8, fetch_rdy=1: sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Asserting rst during an outstanding request gives instr_req=0 next cycle and restarts at BOOT_ADDR.
